// File: rtl/bypass_rx_filter_pkg.sv
// Shared types for the bypass RX filter: header offsets, route width,
// FSM state encodings, table entry layout and the tkeep popcount helper.
package lynxTypes;

   localparam int DATA_W       = 512;
   localparam int KEEP_W       = 64;
   localparam int ROUTE_W      = 14;
   localparam int DMAC_LSB     = 0;
   localparam int DMAC_W       = 48;
   localparam int ETYPE_HI_LSB = 96;
   localparam int ETYPE_LO_LSB = 104;
   localparam int MIN_HDR_LEN  = 14;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_FWD  = 2'd1;
   localparam state_t ST_DROP = 2'd2;

   typedef struct packed {
      logic               en;
      logic [15:0]        etype;
      logic [DMAC_W-1:0]  dmac;
      logic               dmac_en;
      logic [ROUTE_W-1:0] route;
   } cls_entry_t;

   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) begin
         c = c + {6'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/bypass_rx_filter_if.sv
// AXI4-Stream bundle: 512-bit data, 64-bit keep, last, valid/ready.
// Modport m drives the stream, modport s receives it.
interface AXI4S;

   logic                         tvalid;
   logic                         tready;
   logic [lynxTypes::DATA_W-1:0] tdata;
   logic [lynxTypes::KEEP_W-1:0] tkeep;
   logic                         tlast;

   modport m (
      output tvalid, tdata, tkeep, tlast,
      input  tready
   );

   modport s (
      input  tvalid, tdata, tkeep, tlast,
      output tready
   );

endinterface

// File: rtl/bypass_rx_cls_table.sv
// Classification table: entry registers written via cfg port and a
// combinational priority match (lowest index wins) on dst MAC/ethertype.
module bypass_rx_cls_table
   import lynxTypes::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int IDX_W       = 3
) (
   input  logic               nclk,
   input  logic               nresetn,
   input  logic               cfg_wr_i,
   input  logic [IDX_W-1:0]   cfg_idx_i,
   input  cls_entry_t         cfg_entry_i,
   input  logic [DMAC_W-1:0]  dmac_i,
   input  logic [15:0]        etype_i,
   output logic               hit_o,
   output logic [ROUTE_W-1:0] route_o
);

   cls_entry_t ent_q [NUM_ENTRIES];

   always_ff @(posedge nclk) begin
      if (!nresetn) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_q[i] <= '0;
         end
      end else if (cfg_wr_i && (int'(cfg_idx_i) < NUM_ENTRIES)) begin
         ent_q[cfg_idx_i] <= cfg_entry_i;
      end
   end

   // Scan high to low so the lowest matching index is the last writer.
   always_comb begin
      hit_o   = 1'b0;
      route_o = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (ent_q[i].en
             && (ent_q[i].etype == etype_i)
             && (!ent_q[i].dmac_en || (ent_q[i].dmac == dmac_i))) begin
            hit_o   = 1'b1;
            route_o = ent_q[i].route;
         end
      end
   end

endmodule

// File: rtl/bypass_rx_filter.sv
// Filters raw RX frames into the bypass stack: classifies on the first
// beat, forwards matches through one register stage, drops the rest.
// Ports: nclk/nresetn, s_axis_rx in, m_axis_rx out, rx_route_id,
// cfg_* table write port, pass/drop/runt frame counters.
module bypass_rx_filter
   import lynxTypes::*;
#(
   parameter int                 NUM_ENTRIES      = 8,
   parameter bit                 DROP_UNMATCHED   = 1'b1,
   parameter logic [ROUTE_W-1:0] DEFAULT_ROUTE_ID = '0,
   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic               nclk,
   input  logic               nresetn,
   AXI4S.s                    s_axis_rx,
   AXI4S.m                    m_axis_rx,
   output logic [ROUTE_W-1:0] rx_route_id,
   input  logic               cfg_wr,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic               cfg_entry_en,
   input  logic [15:0]        cfg_ethertype,
   input  logic [DMAC_W-1:0]  cfg_dmac,
   input  logic               cfg_dmac_en,
   input  logic [ROUTE_W-1:0] cfg_route_id,
   output logic [31:0]        pass_count,
   output logic [31:0]        drop_count,
   output logic [31:0]        runt_count
);

   state_t              state_q, state_d;
   logic                ov_q, ov_d;
   logic [DATA_W-1:0]   data_q;
   logic [KEEP_W-1:0]   keep_q;
   logic                last_q;
   logic [ROUTE_W-1:0]  route_q, route_d;
   logic [31:0]         pass_q, drop_q, runt_q;

   logic                hit;
   logic [ROUTE_W-1:0]  hit_route;
   logic [DMAC_W-1:0]   hdr_dmac;
   logic [15:0]         hdr_etype;
   cls_entry_t          cfg_ent;
   logic                runt, pass_first, first;
   logic                rdy, s_hs, first_hs, load, out_hs;

   assign hdr_dmac  = s_axis_rx.tdata[DMAC_LSB +: DMAC_W];
   assign hdr_etype = {s_axis_rx.tdata[ETYPE_HI_LSB +: 8],
                       s_axis_rx.tdata[ETYPE_LO_LSB +: 8]};

   assign cfg_ent = '{en:      cfg_entry_en,
                      etype:   cfg_ethertype,
                      dmac:    cfg_dmac,
                      dmac_en: cfg_dmac_en,
                      route:   cfg_route_id};

   bypass_rx_cls_table #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .IDX_W       (IDX_W)
   ) u_table (
      .nclk        (nclk),
      .nresetn     (nresetn),
      .cfg_wr_i    (cfg_wr),
      .cfg_idx_i   (cfg_idx),
      .cfg_entry_i (cfg_ent),
      .dmac_i      (hdr_dmac),
      .etype_i     (hdr_etype),
      .hit_o       (hit),
      .route_o     (hit_route)
   );

   assign runt = s_axis_rx.tlast
              && (popcount64(s_axis_rx.tkeep) < 7'(MIN_HDR_LEN));
   assign pass_first = !runt && (hit || !DROP_UNMATCHED);
   assign first      = (state_q == ST_IDLE) && s_axis_rx.tvalid;

   // Dropped beats are sunk regardless of downstream backpressure.
   always_comb begin
      rdy = 1'b0;
      if (nresetn) begin
         unique case (1'b1)
            (state_q == ST_DROP):   rdy = 1'b1;
            (first && !pass_first): rdy = 1'b1;
            default:                rdy = !ov_q || m_axis_rx.tready;
         endcase
      end
   end

   assign s_hs     = s_axis_rx.tvalid && rdy;
   assign first_hs = first && s_hs;
   assign load     = s_hs && ((state_q == ST_FWD)
                           || (first && pass_first));
   assign out_hs   = ov_q && m_axis_rx.tready;

   always_comb begin
      state_d = state_q;
      unique case (1'b1)
         (state_q == ST_IDLE): begin
            if (first_hs && !s_axis_rx.tlast)
               state_d = pass_first ? ST_FWD : ST_DROP;
         end
         (state_q == ST_FWD),
         (state_q == ST_DROP): begin
            if (s_hs && s_axis_rx.tlast)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ov_d = ov_q;
      if (load)
         ov_d = 1'b1;
      else if (m_axis_rx.tready)
         ov_d = 1'b0;
   end

   always_comb begin
      route_d = route_q;
      if (first_hs && pass_first)
         route_d = hit ? hit_route : DEFAULT_ROUTE_ID;
   end

   always_ff @(posedge nclk) begin
      if (!nresetn) begin
         state_q <= ST_IDLE;
         ov_q    <= 1'b0;
         route_q <= '0;
         pass_q  <= '0;
         drop_q  <= '0;
         runt_q  <= '0;
      end else begin
         state_q <= state_d;
         ov_q    <= ov_d;
         route_q <= route_d;
         if (out_hs && last_q)
            pass_q <= pass_q + 32'd1;
         if (first_hs && !pass_first && !runt)
            drop_q <= drop_q + 32'd1;
         if (first_hs && runt)
            runt_q <= runt_q + 32'd1;
      end
   end

   always_ff @(posedge nclk) begin
      if (load) begin
         data_q <= s_axis_rx.tdata;
         keep_q <= s_axis_rx.tkeep;
         last_q <= s_axis_rx.tlast;
      end
   end

   assign s_axis_rx.tready = rdy;
   assign m_axis_rx.tvalid = ov_q;
   assign m_axis_rx.tdata  = data_q;
   assign m_axis_rx.tkeep  = keep_q;
   assign m_axis_rx.tlast  = last_q;
   assign rx_route_id      = route_q;
   assign pass_count       = pass_q;
   assign drop_count       = drop_q;
   assign runt_count       = runt_q;

endmodule

// File: tb/tb_bypass_rx_filter.sv
// Directed bench for bypass_rx_filter: forwarding, drop, priority,
// runt, random backpressure and mid-frame reset scenarios.
module tb_bypass_rx_filter;
   import lynxTypes::*;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [KEEP_W-1:0] k;
      logic              l;
   } beat_t;

   localparam logic [63:0] FULL = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [47:0] MAC1 = 48'h01_00_00_00_00_02;
   localparam logic [47:0] MAC2 = 48'h02_00_00_00_00_02;

   logic        nclk = 1'b0;
   logic        nresetn = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [2:0]  cfg_idx = '0;
   logic        cfg_entry_en = 1'b0;
   logic [15:0] cfg_ethertype = '0;
   logic [47:0] cfg_dmac = '0;
   logic        cfg_dmac_en = 1'b0;
   logic [13:0] cfg_route_id = '0;
   logic [13:0] rx_route_id;
   logic [31:0] pass_count, drop_count, runt_count;

   int total = 0;
   int bad = 0;
   logic mon_en = 1'b0;
   logic rand_rdy = 1'b0;
   logic stall_q = 1'b0;
   beat_t prev_b;
   beat_t exp_q[$];
   beat_t got_q[$];

   always #5 nclk = ~nclk;

   AXI4S s_if ();
   AXI4S m_if ();

   bypass_rx_filter dut (
      .nclk          (nclk),
      .nresetn       (nresetn),
      .s_axis_rx     (s_if),
      .m_axis_rx     (m_if),
      .rx_route_id   (rx_route_id),
      .cfg_wr        (cfg_wr),
      .cfg_idx       (cfg_idx),
      .cfg_entry_en  (cfg_entry_en),
      .cfg_ethertype (cfg_ethertype),
      .cfg_dmac      (cfg_dmac),
      .cfg_dmac_en   (cfg_dmac_en),
      .cfg_route_id  (cfg_route_id),
      .pass_count    (pass_count),
      .drop_count    (drop_count),
      .runt_count    (runt_count)
   );

   always @(posedge nclk) begin
      if (mon_en && nresetn) begin
         if (stall_q) begin
            total++;
            if (!m_if.tvalid || {m_if.tdata, m_if.tkeep, m_if.tlast} !== prev_b) begin
               bad++;
               $display("FAIL stall_hold valid=%b last=%b", m_if.tvalid, m_if.tlast);
            end
         end
         if (m_if.tvalid && m_if.tready)
            got_q.push_back('{d: m_if.tdata, k: m_if.tkeep, l: m_if.tlast});
      end
      stall_q = m_if.tvalid && !m_if.tready;
      prev_b  = '{d: m_if.tdata, k: m_if.tkeep, l: m_if.tlast};
   end

   always @(posedge nclk) begin
      if (rand_rdy) begin
         #1;
         m_if.tready = 1'($urandom_range(0, 1));
      end
   end

   function automatic logic [DATA_W-1:0] rnd_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [DATA_W-1:0] mkhdr(input logic [47:0] mac,
                                               input logic [15:0] et);
      logic [DATA_W-1:0] d;
      d = rnd_data();
      d[47:0]    = mac;
      d[103:96]  = et[15:8];
      d[111:104] = et[7:0];
      return d;
   endfunction

   task automatic cfg_write(input int idx, input bit en,
                            input logic [15:0] et, input logic [47:0] mac,
                            input bit men, input logic [13:0] rt);
      cfg_wr        = 1'b1;
      cfg_idx       = 3'(idx);
      cfg_entry_en  = en;
      cfg_ethertype = et;
      cfg_dmac      = mac;
      cfg_dmac_en   = men;
      cfg_route_id  = rt;
      @(posedge nclk); #1;
      cfg_wr = 1'b0;
   endtask

   task automatic drive_beat(input beat_t b);
      int n;
      s_if.tvalid = 1'b1;
      s_if.tdata  = b.d;
      s_if.tkeep  = b.k;
      s_if.tlast  = b.l;
      n = 0;
      while (1) begin
         @(negedge nclk);
         if (s_if.tready) break;
         n++;
         if (n > 500) begin
            total++; bad++;
            $display("FAIL drive_timeout waited=%0d need=accept", n);
            break;
         end
      end
      @(posedge nclk); #1;
      s_if.tvalid = 1'b0;
   endtask

   task automatic test_reset();
      nresetn = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata  = mkhdr(MAC1, 16'h88B5);
      s_if.tkeep  = FULL;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      repeat (3) @(posedge nclk);
      @(negedge nclk);
      total++;
      if (s_if.tready !== 1'b0) begin
         bad++; $display("FAIL rst_tready got=%b exp=0", s_if.tready);
      end
      total++;
      if (m_if.tvalid !== 1'b0) begin
         bad++; $display("FAIL rst_tvalid got=%b exp=0", m_if.tvalid);
      end
      total++;
      if ({rx_route_id, pass_count, drop_count, runt_count} !== '0) begin
         bad++;
         $display("FAIL rst_regs route=%h pass=%0d drop=%0d runt=%0d exp=0",
                  rx_route_id, pass_count, drop_count, runt_count);
      end
      s_if.tvalid = 1'b0;
      @(posedge nclk); #1;
      nresetn = 1'b1;
      @(posedge nclk); #1;
   endtask

   task automatic test_matched();
      beat_t b [3];
      cfg_write(0, 1, 16'h88B5, '0, 0, 14'h005);
      m_if.tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b[i].d = (i == 0) ? mkhdr(48'h1234_5678_9ABC, 16'h88B5) : rnd_data();
         b[i].k = FULL;
         b[i].l = (i == 2);
      end
      for (int i = 0; i < 3; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = b[i].d;
         s_if.tkeep  = b[i].k;
         s_if.tlast  = b[i].l;
         @(negedge nclk);
         total++;
         if (s_if.tready !== 1'b1) begin
            bad++; $display("FAIL fwd_tready beat=%0d got=%b exp=1", i, s_if.tready);
         end
         @(posedge nclk); #1;
         total++;
         if (m_if.tvalid !== 1'b1 || m_if.tdata !== b[i].d || m_if.tlast !== b[i].l) begin
            bad++;
            $display("FAIL fwd_beat%0d valid=%b last=%b data=%h exp_data=%h",
                     i, m_if.tvalid, m_if.tlast, m_if.tdata[63:0], b[i].d[63:0]);
         end
         if (i == 0) begin
            total++;
            if (rx_route_id !== 14'h005) begin
               bad++; $display("FAIL fwd_route got=%h exp=005", rx_route_id);
            end
         end
      end
      s_if.tvalid = 1'b0;
      @(posedge nclk); #1;
      total++;
      if (pass_count !== 32'd1 || m_if.tvalid !== 1'b0 || rx_route_id !== 14'h005) begin
         bad++;
         $display("FAIL fwd_end pass=%0d valid=%b route=%h exp=1/0/005",
                  pass_count, m_if.tvalid, rx_route_id);
      end
   endtask

   task automatic test_drop();
      m_if.tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = (i == 0) ? mkhdr(MAC1, 16'h0800) : rnd_data();
         s_if.tkeep  = FULL;
         s_if.tlast  = (i == 3);
         @(negedge nclk);
         total++;
         if (s_if.tready !== 1'b1 || m_if.tvalid !== 1'b0) begin
            bad++;
            $display("FAIL drop_beat%0d tready=%b tvalid=%b exp=1/0",
                     i, s_if.tready, m_if.tvalid);
         end
         @(posedge nclk); #1;
      end
      s_if.tvalid = 1'b0;
      @(posedge nclk); #1;
      total++;
      if (drop_count !== 32'd1 || pass_count !== 32'd1 || m_if.tvalid !== 1'b0) begin
         bad++;
         $display("FAIL drop_end drop=%0d pass=%0d valid=%b exp=1/1/0",
                  drop_count, pass_count, m_if.tvalid);
      end
      m_if.tready = 1'b1;
   endtask

   task automatic test_priority();
      cfg_write(0, 0, 16'h88B5, '0, 0, 14'h005);
      cfg_write(1, 1, 16'h88B5, MAC1, 1, 14'd7);
      cfg_write(3, 1, 16'h88B5, '0, 0, 14'd9);
      drive_beat('{d: mkhdr(MAC1, 16'h88B5), k: FULL, l: 1'b1});
      total++;
      if (m_if.tvalid !== 1'b1 || rx_route_id !== 14'd7) begin
         bad++; $display("FAIL prio_mac valid=%b route=%0d exp=1/7", m_if.tvalid, rx_route_id);
      end
      drive_beat('{d: mkhdr(MAC2, 16'h88B5), k: FULL, l: 1'b1});
      total++;
      if (m_if.tvalid !== 1'b1 || rx_route_id !== 14'd9) begin
         bad++; $display("FAIL prio_nomac valid=%b route=%0d exp=1/9", m_if.tvalid, rx_route_id);
      end
      @(posedge nclk); #1;
      total++;
      if (pass_count !== 32'd3) begin
         bad++; $display("FAIL prio_pass got=%0d exp=3", pass_count);
      end
   endtask

   task automatic test_runt();
      drive_beat('{d: mkhdr(MAC2, 16'h88B5), k: 64'h0FFF, l: 1'b1});
      total++;
      if (m_if.tvalid !== 1'b0 || runt_count !== 32'd1 || drop_count !== 32'd1) begin
         bad++;
         $display("FAIL runt valid=%b runt=%0d drop=%0d exp=0/1/1",
                  m_if.tvalid, runt_count, drop_count);
      end
      drive_beat('{d: mkhdr(MAC2, 16'h88B5), k: 64'h3FFF, l: 1'b1});
      total++;
      if (m_if.tvalid !== 1'b1 || m_if.tkeep !== 64'h3FFF || runt_count !== 32'd1) begin
         bad++;
         $display("FAIL min_hdr valid=%b keep=%h runt=%0d exp=1/3fff/1",
                  m_if.tvalid, m_if.tkeep, runt_count);
      end
      @(posedge nclk); #1;
      total++;
      if (pass_count !== 32'd4) begin
         bad++; $display("FAIL min_hdr_pass got=%0d exp=4", pass_count);
      end
   endtask

   task automatic test_back_to_back();
      int nb, n;
      beat_t b;
      exp_q.delete();
      got_q.delete();
      mon_en   = 1'b1;
      rand_rdy = 1'b1;
      for (int f = 0; f < 10; f++) begin
         nb = (f == 0) ? 1 : (f == 1) ? 64 : $urandom_range(1, 64);
         for (int j = 0; j < nb; j++) begin
            b.d = (j == 0) ? mkhdr({16'hAA00, 32'($urandom)}, 16'h88B5) : rnd_data();
            b.k = (j == nb - 1 && nb > 1) ? (FULL >> $urandom_range(0, 63)) : FULL;
            b.l = (j == nb - 1);
            exp_q.push_back(b);
            drive_beat(b);
         end
      end
      n = 0;
      while (got_q.size() < exp_q.size() && n < 2000) begin
         @(posedge nclk); #1;
         n++;
      end
      rand_rdy = 1'b0;
      @(posedge nclk); #2;
      m_if.tready = 1'b1;
      @(posedge nclk); #1;
      mon_en = 1'b0;
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL b2b_beat%0d got=%h/%h/%b exp=%h/%h/%b", i,
                     got_q[i].d[63:0], got_q[i].k, got_q[i].l,
                     exp_q[i].d[63:0], exp_q[i].k, exp_q[i].l);
         end
      end
      total++;
      if (pass_count !== 32'd14 || rx_route_id !== 14'd9) begin
         bad++;
         $display("FAIL b2b_end pass=%0d route=%0d exp=14/9", pass_count, rx_route_id);
      end
   endtask

   task automatic test_reset_mid();
      beat_t b [3];
      cfg_write(2, 1, 16'h88B5, '0, 0, 14'h0AB);
      m_if.tready = 1'b1;
      drive_beat('{d: mkhdr(MAC2, 16'h88B5), k: FULL, l: 1'b0});
      s_if.tvalid = 1'b1;
      s_if.tdata  = rnd_data();
      s_if.tlast  = 1'b0;
      nresetn     = 1'b0;
      @(negedge nclk);
      total++;
      if (s_if.tready !== 1'b0) begin
         bad++; $display("FAIL mid_rst_tready got=%b exp=0", s_if.tready);
      end
      @(posedge nclk); #1;
      @(posedge nclk); #1;
      s_if.tvalid = 1'b0;
      total++;
      if ({pass_count, drop_count, runt_count, rx_route_id} !== '0
          || m_if.tvalid !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst_regs pass=%0d drop=%0d runt=%0d route=%h valid=%b",
                  pass_count, drop_count, runt_count, rx_route_id, m_if.tvalid);
      end
      nresetn = 1'b1;
      @(posedge nclk); #1;
      drive_beat('{d: mkhdr(MAC2, 16'h88B5), k: FULL, l: 1'b1});
      total++;
      if (drop_count !== 32'd1 || m_if.tvalid !== 1'b0) begin
         bad++;
         $display("FAIL post_rst_hdr drop=%0d valid=%b exp=1/0", drop_count, m_if.tvalid);
      end
      cfg_write(2, 1, 16'h88B5, '0, 0, 14'h0AB);
      for (int i = 0; i < 3; i++) begin
         b[i].d = (i == 0) ? mkhdr(MAC2, 16'h88B5) : rnd_data();
         b[i].k = FULL;
         b[i].l = (i == 2);
      end
      drive_beat(b[0]);
      total++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata !== b[0].d || rx_route_id !== 14'h0AB) begin
         bad++;
         $display("FAIL post_rst_fwd valid=%b route=%h exp=1/0ab", m_if.tvalid, rx_route_id);
      end
      drive_beat(b[1]);
      drive_beat(b[2]);
      @(posedge nclk); #1;
      total++;
      if (pass_count !== 32'd1 || drop_count !== 32'd1) begin
         bad++;
         $display("FAIL post_rst_cnt pass=%0d drop=%0d exp=1/1", pass_count, drop_count);
      end
   endtask

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tkeep  = '0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      test_reset();
      test_matched();
      test_drop();
      test_priority();
      test_runt();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bypass_rx_filter.md
BYPASS_RX_FILTER -- requirements
Module: bypass_rx_filter

Interface
REQ-001 Parameter NUM_ENTRIES, default 8: number of classification table entries.
REQ-002 Parameter DROP_UNMATCHED, default 1: 1 drops frames matching no entry; 0 forwards them with DEFAULT_ROUTE_ID.
REQ-003 Parameter DEFAULT_ROUTE_ID, default 0: 14-bit route for unmatched frames when DROP_UNMATCHED=0.
REQ-004 nclk  input  1  clock; reset nresetn, synchronous, active-low; clock nclk.
REQ-005 nresetn  input  1  synchronous active-low reset.
REQ-006 s_axis_rx  AXI4S.s  512 data/64 keep/last  raw Ethernet frames from the network RX port.
REQ-007 m_axis_rx  AXI4S.m  512 data/64 keep/last  accepted frames to the bypass stack RX input.
REQ-008 rx_route_id  output  14  route of the frame currently on m_axis_rx; held after its tlast until the next frame's first beat.
REQ-009 cfg_wr  input  1  table write strobe.
REQ-010 cfg_idx  input  $clog2(NUM_ENTRIES)  entry index to write.
REQ-011 cfg_entry_en, cfg_ethertype[15:0], cfg_dmac[47:0], cfg_dmac_en, cfg_route_id[13:0]  inputs  entry contents.
REQ-012 pass_count, drop_count, runt_count  outputs  32 each  frame statistics.

Function
REQ-013 Header fields SHALL be taken from the first beat: dst MAC = tdata[47:0] (byte 0 in [7:0]); ethertype = {tdata[103:96], tdata[111:104]}.
REQ-014 An entry SHALL match when it is enabled, the ethertype is equal, and either cfg_dmac_en=0 or the dst MAC is equal.
REQ-015 When several entries match, the lowest-index entry SHALL win.
REQ-016 A first beat with tlast=1 and popcount(tkeep)<14 SHALL be a runt: dropped, runt_count incremented, drop_count not incremented.
REQ-017 FSM states: IDLE (await first beat), FWD (forwarding the remaining beats), DROP (discarding the remaining beats).
REQ-018 IDLE transitions on first-beat handshake:
- tlast=0: to FWD on pass, to DROP on drop.
- tlast=1: stay in IDLE.
REQ-019 FWD and DROP SHALL return to IDLE on a tlast handshake.
REQ-020 The decision and route SHALL be latched on the first beat and used for the whole frame.
REQ-021 Forwarded beats SHALL pass through one output register stage: a beat accepted in cycle N is valid on m_axis_rx in cycle N+1.
REQ-022 tdata, tkeep and tlast SHALL be forwarded unmodified.
REQ-023 s_axis_rx.tready SHALL be 1 in DROP and for dropped first beats, regardless of m_axis_rx.tready.
REQ-024 Otherwise s_axis_rx.tready SHALL equal (!out_valid || m_axis_rx.tready), giving full throughput with no bubbles.
REQ-025 m_axis_rx.tvalid SHALL remain asserted with stable data until the handshake completes.
REQ-026 rx_route_id SHALL update in the same cycle the frame's first beat becomes valid on m_axis_rx.
REQ-027 pass_count SHALL increment on each forwarded tlast output handshake.
REQ-028 drop_count SHALL increment once per dropped non-runt frame, at its first beat.
REQ-029 All counters SHALL wrap modulo 2^32.
REQ-030 cfg_wr SHALL update the entry at the next clock edge; frames whose first beat is accepted in that cycle or earlier use the old contents.
REQ-031 A cfg_wr to the entry in use SHALL NOT alter the decision of an in-flight frame.

Reset
REQ-032 On reset: FSM to IDLE, m_axis_rx.tvalid=0, rx_route_id=0, all counters=0, all entries disabled.
REQ-033 Reset mid-frame SHALL abandon the frame; the next accepted beat after reset is treated as a first beat.
REQ-034 s_axis_rx.tready SHALL be 0 while nresetn=0.

Structure
REQ-035 The route-id width (14), header byte offsets, minimum header length (14) and the FSM state enum SHALL be placed in lynxTypes.
REQ-036 The 64-bit tkeep popcount SHALL be the shared function in lynxTypes.
REQ-037 One sub-module, bypass_rx_cls_table, SHALL hold the entry registers and the priority-match logic (combinational match output).
REQ-038 Implementation size is 150-300 lines.

Verification
REQ-039 Matched forward: entry0 {ethertype 0x88B5, route 0x005}; send a 3-beat frame with ethertype 0x88B5 -> 3 beats out, each 1 cycle later; rx_route_id=0x005; pass_count=1.
REQ-040 Unmatched drop: DROP_UNMATCHED=1; send an ethertype 0x0800 4-beat frame with m_axis_rx.tready=0 -> tready stays 1; no output beats; drop_count=1.
REQ-041 Priority and MAC match:
- entry1 {0x88B5, dmac 02:00:00:00:00:01, route 7}; entry3 {0x88B5, no MAC, route 9}.
- Frame to MAC ...:01 -> route 7.
- Frame to MAC ...:02 -> route 9.
REQ-042 Runt: single beat, tkeep=0x0FFF (12 bytes), tlast=1 -> dropped; runt_count=1; drop_count=0.
REQ-043 Backpressure: random m_axis_rx.tready on ten back-to-back 1-64 beat frames -> output byte-exact and in order; pass_count=10; no beat duplicated or lost.
REQ-044 Reset mid-frame: assert nresetn=0 on beat 2 of 5, then release -> counters 0; the next beat is classified as a frame header.
